// File: rtl/proc_control_unit_pkg.sv
// proc_control_unit_pkg
//   Shared definitions for the cs147sec05 control unit: state encodings,
//   CTRL bit positions, opcode/funct constants, ALU operation codes and a
//   helper that classifies an instruction into the behaviour class that
//   drives the decoder.
package proc_control_unit_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_e;

    typedef enum logic [5:0] {
        ALU_NONE = 6'd0,
        ALU_ADD  = 6'd1,
        ALU_SUB  = 6'd2,
        ALU_MUL  = 6'd3,
        ALU_SHR  = 6'd4,
        ALU_SHL  = 6'd5,
        ALU_AND  = 6'd6,
        ALU_OR   = 6'd7,
        ALU_NOR  = 6'd8,
        ALU_SLT  = 6'd9
    } alu_op_e;

    // Behaviour class: instructions in one class share their CTRL pattern.
    typedef enum logic [3:0] {
        K_ILLEGAL, K_ALU_R, K_SHIFT, K_JR, K_ALU_I, K_LUI, K_BEQ, K_BNE,
        K_LW, K_SW, K_JMP, K_JAL, K_PUSH, K_POP
    } kind_e;

    typedef struct packed {
        kind_e   kind;
        alu_op_e alu;
        logic    imm_sext;   // 0 selects the zero-extended immediate
    } decode_t;

    // CTRL bit positions
    localparam int B_PC_LOAD   = 0;
    localparam int B_PC_SEL_1  = 1;
    localparam int B_PC_SEL_2  = 2;
    localparam int B_PC_SEL_3  = 3;
    localparam int B_IR_LOAD   = 4;
    localparam int B_REG_R     = 6;
    localparam int B_REG_W     = 7;
    localparam int B_R1_SEL    = 8;
    localparam int B_SP_LOAD   = 9;
    localparam int B_OP1_SEL   = 10;
    localparam int B_OP2_SEL_1 = 11;
    localparam int B_OP2_SEL_2 = 12;
    localparam int B_OP2_SEL_3 = 13;
    localparam int B_OP2_SEL_4 = 14;
    localparam int B_ALU_LSB   = 15;
    localparam int B_MA_SEL_1  = 21;
    localparam int B_MA_SEL_2  = 22;
    localparam int B_MD_SEL    = 23;
    localparam int B_MEM_R     = 24;
    localparam int B_MEM_W     = 25;
    localparam int B_WD_SEL_1  = 26;
    localparam int B_WD_SEL_2  = 27;
    localparam int B_WD_SEL_3  = 28;
    localparam int B_WA_SEL_1  = 29;
    localparam int B_WA_SEL_2  = 30;
    localparam int B_WA_SEL_3  = 31;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_MULI  = 6'h1d;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_JMP   = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_PUSH  = 6'h1b;
    localparam logic [5:0] OP_POP   = 6'h1c;

    // R-type funct codes
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_MUL = 6'h2c;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2a;
    localparam logic [5:0] F_SLL = 6'h01;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_JR  = 6'h08;

    function automatic decode_t classify(input logic [5:0] op, input logic [5:0] funct);
        decode_t d;
        d.kind     = K_ILLEGAL;
        d.alu      = ALU_NONE;
        d.imm_sext = 1'b1;
        case (op)
            OP_RTYPE: begin
                d.kind = K_ALU_R;
                case (funct)
                    F_ADD:   d.alu = ALU_ADD;
                    F_SUB:   d.alu = ALU_SUB;
                    F_MUL:   d.alu = ALU_MUL;
                    F_AND:   d.alu = ALU_AND;
                    F_OR:    d.alu = ALU_OR;
                    F_NOR:   d.alu = ALU_NOR;
                    F_SLT:   d.alu = ALU_SLT;
                    F_SLL:   begin d.kind = K_SHIFT; d.alu = ALU_SHL; end
                    F_SRL:   begin d.kind = K_SHIFT; d.alu = ALU_SHR; end
                    F_JR:    d.kind = K_JR;
                    default: d.kind = K_ILLEGAL;
                endcase
            end
            OP_ADDI: begin d.kind = K_ALU_I; d.alu = ALU_ADD; end
            OP_MULI: begin d.kind = K_ALU_I; d.alu = ALU_MUL; end
            OP_ANDI: begin d.kind = K_ALU_I; d.alu = ALU_AND; d.imm_sext = 1'b0; end
            OP_ORI:  begin d.kind = K_ALU_I; d.alu = ALU_OR;  d.imm_sext = 1'b0; end
            OP_SLTI: begin d.kind = K_ALU_I; d.alu = ALU_SLT; end
            OP_LUI:  d.kind = K_LUI;
            OP_BEQ:  begin d.kind = K_BEQ; d.alu = ALU_SUB; end
            OP_BNE:  begin d.kind = K_BNE; d.alu = ALU_SUB; end
            OP_LW:   begin d.kind = K_LW;  d.alu = ALU_ADD; end
            OP_SW:   begin d.kind = K_SW;  d.alu = ALU_ADD; end
            OP_JMP:  d.kind = K_JMP;
            OP_JAL:  d.kind = K_JAL;
            OP_PUSH: begin d.kind = K_PUSH; d.alu = ALU_SUB; end
            OP_POP:  begin d.kind = K_POP;  d.alu = ALU_ADD; end
            default: d.kind = K_ILLEGAL;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/proc_control_unit_cu_decoder.sv
// cu_decoder
//   Combinational map from (state, opcode, funct, zero) to the CTRL word.
//   Ports:
//     state  - current sequencer state
//     opcode - INSTRUCTION[31:26]
//     funct  - INSTRUCTION[5:0]
//     zero   - ALU zero flag, used by beq/bne in WRITEBACK
//     ctrl   - control word (bit 5 reserved, always 0)
module cu_decoder
    import proc_control_unit_pkg::*;
#(
    parameter int CTRL_WIDTH = 32
) (
    input  state_e                state,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    output logic [CTRL_WIDTH-1:0] ctrl
);

    decode_t dec;
    assign dec = classify(opcode, funct);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        ctrl = '0;

        // ALU operation and operand selects stay fixed from EXECUTE through
        // WRITEBACK so ZERO and the ALU result remain valid for later states.
        if (state inside {ST_EXECUTE, ST_MEMORY, ST_WRITEBACK}) begin
            ctrl[B_ALU_LSB +: 6] = dec.alu;
            case (dec.kind)
                K_ALU_R, K_BEQ, K_BNE: ctrl[B_OP2_SEL_4] = 1'b1;
                K_SHIFT: begin
                    ctrl[B_OP2_SEL_3] = 1'b1;
                    ctrl[B_OP2_SEL_1] = 1'b1;
                end
                K_ALU_I, K_LW, K_SW: ctrl[B_OP2_SEL_2] = dec.imm_sext;
                K_PUSH, K_POP: begin
                    // SP -/+ constant 1
                    ctrl[B_OP1_SEL]   = 1'b1;
                    ctrl[B_OP2_SEL_3] = 1'b1;
                end
                default: ;
            endcase
        end

        case (state)
            ST_FETCH: begin
                ctrl[B_MA_SEL_2] = 1'b1;
                ctrl[B_MEM_R]    = 1'b1;
                ctrl[B_IR_LOAD]  = 1'b1;
            end
            ST_DECODE: begin
                ctrl[B_REG_R]  = 1'b1;
                ctrl[B_R1_SEL] = (dec.kind == K_PUSH);
            end
            ST_EXECUTE: begin
                ctrl[B_SP_LOAD] = (dec.kind == K_POP);
            end
            ST_MEMORY: begin
                case (dec.kind)
                    K_LW: ctrl[B_MEM_R] = 1'b1;
                    K_SW: ctrl[B_MEM_W] = 1'b1;
                    K_PUSH: begin
                        ctrl[B_MEM_W]    = 1'b1;
                        ctrl[B_MA_SEL_1] = 1'b1;
                        ctrl[B_MD_SEL]   = 1'b1;
                    end
                    K_POP: begin
                        ctrl[B_MEM_R]    = 1'b1;
                        ctrl[B_MA_SEL_1] = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_WRITEBACK: begin
                ctrl[B_PC_LOAD]  = 1'b1;
                ctrl[B_PC_SEL_1] = 1'b1;
                ctrl[B_PC_SEL_3] = 1'b1;
                case (dec.kind)
                    K_ALU_R, K_SHIFT: begin
                        ctrl[B_REG_W]    = 1'b1;
                        ctrl[B_WA_SEL_3] = 1'b1;
                        ctrl[B_WA_SEL_1] = 1'b1;
                        ctrl[B_WD_SEL_3] = 1'b1;
                    end
                    K_ALU_I: begin
                        ctrl[B_REG_W]    = 1'b1;
                        ctrl[B_WA_SEL_3] = 1'b1;
                        ctrl[B_WD_SEL_3] = 1'b1;
                    end
                    K_LW: begin
                        ctrl[B_REG_W]    = 1'b1;
                        ctrl[B_WA_SEL_3] = 1'b1;
                        ctrl[B_WD_SEL_3] = 1'b1;
                        ctrl[B_WD_SEL_1] = 1'b1;
                    end
                    K_LUI: begin
                        ctrl[B_REG_W]    = 1'b1;
                        ctrl[B_WA_SEL_3] = 1'b1;
                        ctrl[B_WD_SEL_3] = 1'b1;
                        ctrl[B_WD_SEL_2] = 1'b1;
                    end
                    K_POP: begin
                        // DATA_IN into R0 (wa_sel_3=0, wa_sel_2=0)
                        ctrl[B_REG_W]    = 1'b1;
                        ctrl[B_WD_SEL_3] = 1'b1;
                        ctrl[B_WD_SEL_1] = 1'b1;
                    end
                    K_JAL: begin
                        // PC+1 into R31
                        ctrl[B_REG_W]    = 1'b1;
                        ctrl[B_WA_SEL_2] = 1'b1;
                        ctrl[B_PC_SEL_3] = 1'b0;
                    end
                    K_JMP:  ctrl[B_PC_SEL_3] = 1'b0;
                    K_JR:   ctrl[B_PC_SEL_1] = 1'b0;
                    K_BEQ:  ctrl[B_PC_SEL_2] = zero;
                    K_BNE:  ctrl[B_PC_SEL_2] = ~zero;
                    K_PUSH: ctrl[B_SP_LOAD]  = 1'b1;
                    default: ;
                endcase
            end
            default: ;  // TRAP: everything stays 0
        endcase
    end

endmodule

// File: rtl/proc_control_unit.sv
// proc_control_unit
//   Five-state multi-cycle sequencer (FETCH, DECODE, EXECUTE, MEMORY,
//   WRITEBACK) for the cs147sec05 processor.
//   Ports:
//     CLK         - clock, rising edge
//     RST         - synchronous active-high reset; forces CTRL to 0 while high
//     INSTRUCTION - IR contents, stable from DECODE onward
//     ZERO        - ALU zero flag
//     CTRL        - control word (see cu_decoder)
//     STATE       - current state, for debug
//     ILLEGAL     - sticky illegal-opcode flag
//   Build option: CU_ILLEGAL_TRAP_EN routes unknown opcode/funct from DECODE
//   into TRAP (CTRL=0, ILLEGAL=1 until RST). Without it unknown encodings
//   run as a NOP and ILLEGAL is tied 0.
module proc_control_unit
    import proc_control_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] INSTRUCTION,
    input  logic                  ZERO,
    output logic [CTRL_WIDTH-1:0] CTRL,
    output logic [2:0]            STATE,
    output logic                  ILLEGAL
);

    state_e                state_q, state_d;
    logic [5:0]            opcode, funct;
    logic [CTRL_WIDTH-1:0] dec_ctrl;
    logic                  unused_instr_bits;

    assign opcode            = INSTRUCTION[DATA_WIDTH-1 -: 6];
    assign funct             = INSTRUCTION[5:0];
    assign unused_instr_bits = ^INSTRUCTION[DATA_WIDTH-7:6];

    cu_decoder #(.CTRL_WIDTH(CTRL_WIDTH)) u_decoder (
        .state  (state_q),
        .opcode (opcode),
        .funct  (funct),
        .zero   (ZERO),
        .ctrl   (dec_ctrl)
    );

    assign CTRL  = RST ? '0 : dec_ctrl;
    assign STATE = state_q;

`ifdef CU_ILLEGAL_TRAP_EN
    decode_t dec;
    logic    illegal_q, illegal_d;
    assign dec       = classify(opcode, funct);
    assign illegal_d = illegal_q | ((state_q == ST_DECODE) && (dec.kind == K_ILLEGAL));
    assign ILLEGAL   = illegal_q;
`else
    assign ILLEGAL = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:     state_d = ST_DECODE;
`ifdef CU_ILLEGAL_TRAP_EN
            ST_DECODE:    state_d = (dec.kind == K_ILLEGAL) ? ST_TRAP : ST_EXECUTE;
            ST_TRAP:      state_d = ST_TRAP;
`else
            ST_DECODE:    state_d = ST_EXECUTE;
            ST_TRAP:      state_d = ST_FETCH;
`endif
            ST_EXECUTE:   state_d = ST_MEMORY;
            ST_MEMORY:    state_d = ST_WRITEBACK;
            ST_WRITEBACK: state_d = ST_FETCH;
            default:      state_d = ST_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_FETCH;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

endmodule
